v810_writeback: RTL and testbench

//  Write side of the V810 register file: merges single-cycle EX results and

---
 rtl/v810_pkg.sv | 22 ++
 rtl/v810_wb_chk.sv | 20 ++
 rtl/v810_wb_lq.sv | 58 +++++
 rtl/v810_writeback.sv | 138 +++++++++++++
 tb/tb_v810_writeback.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/v810_pkg.sv
// Shared types for the V810 register-file write side: register address, data word
// and the write request carried through the load-return queue.
package v810_pkg;

   typedef logic [4:0]  reg_addr_t;
   typedef logic [31:0] word_t;

   typedef struct packed {
      reg_addr_t wa;
      word_t     wd;
   } wb_req_t;

   localparam int LQ_DEPTH_DEF = 2;

   function automatic word_t reg_mask(input reg_addr_t a);
      word_t m;
      m    = 32'd0;
      m[a] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/v810_wb_chk.sv
// Protocol checks on the scoreboard handshakes: no issue to a pending register,
// no load return to a register that is not pending (r0 is exempt from both).
module v810_wb_chk (
   input logic        clk_i,
   input logic        rst_ni,
   input logic        ce_i,
   input logic        sb_issue_i,
   input logic [4:0]  sb_wa_i,
   input logic        ld_push_i,
   input logic [4:0]  ld_wa_i,
   input logic [31:0] pend_i
);

   a_issue_not_pending: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (ce_i && sb_issue_i && (sb_wa_i != 5'd0)) |-> !pend_i[sb_wa_i]);

   a_load_is_pending: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (ld_push_i && (ld_wa_i != 5'd0)) |-> pend_i[ld_wa_i]);

endmodule

// File: rtl/v810_wb_lq.sv
// Load-return queue: synchronous FIFO of write requests. The caller guarantees
// no push when full and no pop when empty; clock enable is folded into push/pop.
module v810_wb_lq
   import v810_pkg::*;
#(
   parameter int LQ_DEPTH = LQ_DEPTH_DEF
) (
   input  logic    clk_i,
   input  logic    rst_ni,
   input  logic    push_i,
   input  wb_req_t push_data_i,
   input  logic    pop_i,
   output wb_req_t head_o,
   output logic    full_o,
   output logic    empty_o
);

   localparam int PW = $clog2(LQ_DEPTH);
   localparam int CW = PW + 1;

   wb_req_t          mem_q [LQ_DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [CW-1:0]    cnt_q;

   // Storage array, written only on push
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_i) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (pop_i) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         case ({push_i, pop_i})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign full_o  = (cnt_q == CW'(LQ_DEPTH));
   assign empty_o = (cnt_q == CW'(0));

endmodule

// File: rtl/v810_writeback.sv
// V810 register-file write side: arbitrates EX results against queued load data
// onto the single registered write port and tracks pending loads for decode.
module v810_writeback
   import v810_pkg::*;
#(
   parameter int LQ_DEPTH = LQ_DEPTH_DEF
) (
   input  logic        CLK,
   input  logic        RESn,
   input  logic        CE,
   input  logic        EX_VALID,
   input  logic [4:0]  EX_WA,
   input  logic [31:0] EX_WD,
   output logic        EX_READY,
   input  logic        SB_ISSUE,
   input  logic [4:0]  SB_WA,
   input  logic        LD_VALID,
   input  logic [4:0]  LD_WA,
   input  logic [31:0] LD_WD,
   output logic        LD_READY,
   input  logic [4:0]  HZ_RA1,
   input  logic [4:0]  HZ_RA2,
   input  logic [4:0]  HZ_WA,
   output logic        HZ_STALL,
   output logic [4:0]  WA,
   output logic [31:0] WD,
   output logic        WE
);

   wb_req_t   ld_req_s;
   wb_req_t   head_s;
   wb_req_t   sel_s;
   logic      lq_full_s;
   logic      lq_empty_s;
   logic      lq_push_s;
   logic      lq_pop_s;
   logic      sel_valid_s;
   logic      sel_from_lq_s;
   word_t     set_mask_s;
   word_t     clr_mask_s;
   word_t     pend_d;
   word_t     pend_q;
   reg_addr_t wa_q;
   word_t     wd_q;
   logic      we_q;

   assign ld_req_s.wa = LD_WA;
   assign ld_req_s.wd = LD_WD;

   v810_wb_lq #(.LQ_DEPTH(LQ_DEPTH)) u_lq (
      .clk_i       (CLK),
      .rst_ni      (RESn),
      .push_i      (lq_push_s),
      .push_data_i (ld_req_s),
      .pop_i       (lq_pop_s),
      .head_o      (head_s),
      .full_o      (lq_full_s),
      .empty_o     (lq_empty_s)
   );

   // Write-port arbitration: a full queue has priority so loads cannot starve
   always_comb begin
      sel_valid_s   = 1'b0;
      sel_from_lq_s = 1'b0;
      sel_s         = head_s;
      if (lq_full_s) begin
         sel_valid_s   = 1'b1;
         sel_from_lq_s = 1'b1;
      end else if (EX_VALID) begin
         sel_valid_s = 1'b1;
         sel_s.wa    = EX_WA;
         sel_s.wd    = EX_WD;
      end else if (!lq_empty_s) begin
         sel_valid_s   = 1'b1;
         sel_from_lq_s = 1'b1;
      end else begin
         sel_valid_s = 1'b0;
      end
   end

   assign lq_pop_s  = CE & sel_from_lq_s;
   assign lq_push_s = CE & LD_VALID & ~lq_full_s;

   // Scoreboard next state; a same-cycle set overrides the clear
   always_comb begin
      set_mask_s = 32'd0;
      clr_mask_s = 32'd0;
      if (CE && SB_ISSUE && (SB_WA != 5'd0)) begin
         set_mask_s = reg_mask(SB_WA);
      end else begin
         set_mask_s = 32'd0;
      end
      if (lq_pop_s && (head_s.wa != 5'd0)) begin
         clr_mask_s = reg_mask(head_s.wa);
      end else begin
         clr_mask_s = 32'd0;
      end
      pend_d = (pend_q & ~clr_mask_s) | set_mask_s;
   end

   // Registered write port and scoreboard; r0 writes are consumed with WE low
   always_ff @(posedge CLK or negedge RESn) begin
      if (!RESn) begin
         pend_q <= 32'd0;
         wa_q   <= 5'd0;
         wd_q   <= 32'd0;
         we_q   <= 1'b0;
      end else if (CE) begin
         pend_q <= pend_d;
         if (sel_valid_s) begin
            wa_q <= sel_s.wa;
            wd_q <= sel_s.wd;
            we_q <= (sel_s.wa != 5'd0);
         end else begin
            we_q <= 1'b0;
         end
      end
   end

   assign EX_READY = ~lq_full_s;
   assign LD_READY = ~lq_full_s;
   assign HZ_STALL = pend_q[HZ_RA1] | pend_q[HZ_RA2] | pend_q[HZ_WA];
   assign WA       = wa_q;
   assign WD       = wd_q;
   assign WE       = we_q;

   v810_wb_chk u_chk (
      .clk_i      (CLK),
      .rst_ni     (RESn),
      .ce_i       (CE),
      .sb_issue_i (SB_ISSUE),
      .sb_wa_i    (SB_WA),
      .ld_push_i  (lq_push_s),
      .ld_wa_i    (LD_WA),
      .pend_i     (pend_q)
   );

endmodule

// File: tb/tb_v810_writeback.sv
// Bench for v810_writeback: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based reference model.
module tb_v810_writeback;

   localparam int D = 2;

   logic        CLK;
   logic        RESn;
   logic        CE;
   logic        EX_VALID;
   logic [4:0]  EX_WA;
   logic [31:0] EX_WD;
   logic        EX_READY;
   logic        SB_ISSUE;
   logic [4:0]  SB_WA;
   logic        LD_VALID;
   logic [4:0]  LD_WA;
   logic [31:0] LD_WD;
   logic        LD_READY;
   logic [4:0]  HZ_RA1;
   logic [4:0]  HZ_RA2;
   logic [4:0]  HZ_WA;
   logic        HZ_STALL;
   logic [4:0]  WA;
   logic [31:0] WD;
   logic        WE;

   int tests  = 0;
   int failed = 0;

   // Reference model state
   int          mq_wa[$];
   logic [31:0] mq_wd[$];
   bit   [31:0] mpend;
   int          outst[$];
   bit          exp_we;
   int          exp_wa;
   logic [31:0] exp_wd;

   logic [4:0]  sv_wa;
   logic [31:0] sv_wd;
   logic        sv_we;

   v810_writeback #(.LQ_DEPTH(D)) dut (
      .CLK(CLK), .RESn(RESn), .CE(CE),
      .EX_VALID(EX_VALID), .EX_WA(EX_WA), .EX_WD(EX_WD), .EX_READY(EX_READY),
      .SB_ISSUE(SB_ISSUE), .SB_WA(SB_WA),
      .LD_VALID(LD_VALID), .LD_WA(LD_WA), .LD_WD(LD_WD), .LD_READY(LD_READY),
      .HZ_RA1(HZ_RA1), .HZ_RA2(HZ_RA2), .HZ_WA(HZ_WA), .HZ_STALL(HZ_STALL),
      .WA(WA), .WD(WD), .WE(WE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      mq_wa.delete();
      mq_wd.delete();
      outst.delete();
      mpend  = 32'd0;
      exp_we = 1'b0;
      exp_wa = 0;
      exp_wd = 32'd0;
   endtask

   task automatic check_model();
      bit ready;
      bit hz;
      ready = (mq_wa.size() != D);
      hz    = mpend[HZ_RA1] | mpend[HZ_RA2] | mpend[HZ_WA];
      cmp("m_ex_ready", 32'(EX_READY), 32'(ready));
      cmp("m_ld_ready", 32'(LD_READY), 32'(ready));
      cmp("m_hz_stall", 32'(HZ_STALL), 32'(hz));
      cmp("m_we", 32'(WE), 32'(exp_we));
      if (exp_we) begin
         cmp("m_wa", 32'(WA), 32'(exp_wa));
         cmp("m_wd", WD, exp_wd);
      end
   endtask

   // One clock edge of the rules: pick a winner from pre-edge state, then push/issue
   task automatic model_edge();
      bit          full;
      bit          have;
      int          swa;
      logic [31:0] swd;
      if (CE) begin
         full = (mq_wa.size() == D);
         have = 1'b0;
         swa  = 0;
         swd  = 32'd0;
         if (full || (!EX_VALID && mq_wa.size() > 0)) begin
            have = 1'b1;
            swa  = mq_wa.pop_front();
            swd  = mq_wd.pop_front();
            if (swa != 0) mpend[swa] = 1'b0;
         end else if (EX_VALID) begin
            have = 1'b1;
            swa  = int'(EX_WA);
            swd  = EX_WD;
         end
         exp_we = have && (swa != 0);
         if (exp_we) begin
            exp_wa = swa;
            exp_wd = swd;
         end
         if (LD_VALID && !full) begin
            mq_wa.push_back(int'(LD_WA));
            mq_wd.push_back(LD_WD);
            for (int i = 0; i < outst.size(); i++) begin
               if (outst[i] == int'(LD_WA)) begin
                  outst.delete(i);
                  break;
               end
            end
         end
         if (SB_ISSUE && SB_WA != 5'd0) begin
            mpend[SB_WA] = 1'b1;
            outst.push_back(int'(SB_WA));
         end
      end
   endtask

   task automatic step();
      @(negedge CLK);
      check_model();
      model_edge();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      CE       = 1'b1;
      EX_VALID = 1'b0;
      SB_ISSUE = 1'b0;
      LD_VALID = 1'b0;
   endtask

   task automatic ex(input logic [4:0] a, input logic [31:0] d);
      EX_VALID = 1'b1;
      EX_WA    = a;
      EX_WD    = d;
   endtask

   task automatic ld(input logic [4:0] a, input logic [31:0] d);
      LD_VALID = 1'b1;
      LD_WA    = a;
      LD_WD    = d;
   endtask

   task automatic issue(input logic [4:0] a);
      SB_ISSUE = 1'b1;
      SB_WA    = a;
   endtask

   initial begin
      RESn = 1'b0;
      idle();
      EX_WA = 5'd0; EX_WD = 32'd0; SB_WA = 5'd0; LD_WA = 5'd0; LD_WD = 32'd0;
      HZ_RA1 = 5'd0; HZ_RA2 = 5'd0; HZ_WA = 5'd0;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      cmp("rst_we", 32'(WE), 32'd0);
      cmp("rst_wa", 32'(WA), 32'd0);
      cmp("rst_wd", WD, 32'd0);
      cmp("rst_ex_ready", 32'(EX_READY), 32'd1);
      cmp("rst_ld_ready", 32'(LD_READY), 32'd1);
      cmp("rst_hz", 32'(HZ_STALL), 32'd0);
      RESn = 1'b1;

      // EX write, one-cycle latency
      ex(5'd5, 32'h1234_5678);
      step();
      cmp("ex_we", 32'(WE), 32'd1);
      cmp("ex_wa", 32'(WA), 32'd5);
      cmp("ex_wd", WD, 32'h1234_5678);

      // Load issue / return / stall release
      idle(); issue(5'd7);
      step();
      idle(); HZ_RA1 = 5'd7;
      #1;
      cmp("ld_hz_set", 32'(HZ_STALL), 32'd1);
      ld(5'd7, 32'hDEAD_BEEF);
      step();
      cmp("ld_we_early", 32'(WE), 32'd0);
      idle();
      step();
      cmp("ld_we", 32'(WE), 32'd1);
      cmp("ld_wa", 32'(WA), 32'd7);
      cmp("ld_wd", WD, 32'hDEAD_BEEF);
      cmp("ld_hz_clr", 32'(HZ_STALL), 32'd0);
      HZ_RA1 = 5'd0;

      // Two back-to-back loads under continuous EX traffic fill the queue
      issue(5'd8); step();
      idle(); issue(5'd9); step();
      idle(); ex(5'd1, 32'h11); ld(5'd8, 32'h88); step();
      ex(5'd2, 32'h22); ld(5'd9, 32'h99); step();
      LD_VALID = 1'b0; ex(5'd3, 32'h33);
      #1;
      cmp("full_ld_ready", 32'(LD_READY), 32'd0);
      cmp("full_ex_ready", 32'(EX_READY), 32'd0);
      step();
      cmp("full_pop_wa", 32'(WA), 32'd8);
      cmp("full_pop_wd", WD, 32'h88);
      step();
      cmp("full_ex_wa", 32'(WA), 32'd3);
      idle(); step();
      cmp("full_tail_wa", 32'(WA), 32'd9);

      // r0 writes are consumed silently
      ex(5'd0, 32'hAAAA); step();
      cmp("r0_ex_we", 32'(WE), 32'd0);
      idle(); ld(5'd0, 32'h5); step();
      idle(); step();
      cmp("r0_ld_we", 32'(WE), 32'd0);
      #1;
      cmp("r0_hz", 32'(HZ_STALL), 32'd0);

      // Clock-enable freeze
      issue(5'd12); step();
      idle(); ex(5'd4, 32'h44); ld(5'd12, 32'hCC); step();
      sv_we = WE; sv_wa = WA; sv_wd = WD;
      idle(); CE = 1'b0; ex(5'd5, 32'h55);
      for (int i = 0; i < 3; i++) begin
         step();
         cmp("ce_we", 32'(WE), 32'(sv_we));
         cmp("ce_wa", 32'(WA), 32'(sv_wa));
         cmp("ce_wd", WD, sv_wd);
      end
      idle(); step();
      cmp("ce_resume_wa", 32'(WA), 32'd12);
      cmp("ce_resume_wd", WD, 32'hCC);

      // Asynchronous reset with one queued entry
      issue(5'd10); step();
      idle(); ex(5'd11, 32'hBB); ld(5'd10, 32'h1010); step();
      idle(); HZ_RA1 = 5'd10;
      #1;
      cmp("prerst_hz", 32'(HZ_STALL), 32'd1);
      RESn = 1'b0;
      #1;
      cmp("arst_we", 32'(WE), 32'd0);
      cmp("arst_ld_ready", 32'(LD_READY), 32'd1);
      cmp("arst_hz", 32'(HZ_STALL), 32'd0);
      model_reset();
      @(posedge CLK);
      #1;
      RESn = 1'b1;
      HZ_RA1 = 5'd0;

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         int r;
         idle();
         CE = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 1) == 1) ex(5'($urandom_range(0, 31)), $urandom);
         if ($urandom_range(0, 3) == 0) begin
            r = int'($urandom_range(0, 31));
            if (r == 0 || !mpend[r]) issue(5'(r));
         end
         if (outst.size() > 0 && $urandom_range(0, 1) == 1) begin
            ld(5'(outst[$urandom_range(0, outst.size() - 1)]), $urandom);
         end else if ($urandom_range(0, 15) == 0) begin
            ld(5'd0, $urandom);
         end
         HZ_RA1 = 5'($urandom_range(0, 31));
         HZ_RA2 = 5'($urandom_range(0, 31));
         HZ_WA  = 5'($urandom_range(0, 31));
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
